// File: rtl/pong_input_cond.sv
// Pong button conditioning: pad synchronizers, per-button debounce, frame-registered paddle moves and
// a held-score-reset detector. Define PONG_INPUT_DEBOUNCE_EN to enable the debounce counters.
module pong_input_cond #(
    parameter int unsigned DB_CNT_W    = 16,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    input  logic       frame_tick,
    output logic [4:0] btn_stable,
    output logic       left_up,
    output logic       left_down,
    output logic       right_up,
    output logic       right_down,
    output logic       score_clr
);

    localparam int unsigned FC_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [4:0] sync1_q;
    logic [4:0] sync2_q;
    logic       hold_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef PONG_INPUT_DEBOUNCE_EN
    logic [4:0]          stable_q;
    logic [4:0]          stable_d;
    logic [DB_CNT_W-1:0] db_cnt_q [5];
    logic [DB_CNT_W-1:0] db_cnt_d [5];

    // A bit flips only after its synchronized value has disagreed for a full counter wrap.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 5; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (&db_cnt_q[i]) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign btn_stable = stable_q;
    assign hold_next  = stable_d[4];
`else
    assign btn_stable = sync2_q;
    assign hold_next  = sync1_q[4];
`endif

    logic left_up_q, left_down_q, right_up_q, right_down_q;

    // Paddles sample the current (pre-update) debounced levels; opposing presses cancel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_up_q    <= 1'b0;
            left_down_q  <= 1'b0;
            right_up_q   <= 1'b0;
            right_down_q <= 1'b0;
        end else if (frame_tick) begin
            left_up_q    <= btn_stable[0] & ~btn_stable[1];
            left_down_q  <= btn_stable[1] & ~btn_stable[0];
            right_up_q   <= btn_stable[2] & ~btn_stable[3];
            right_down_q <= btn_stable[3] & ~btn_stable[2];
        end
    end

    logic [1:0]      state_q, state_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            score_clr_q, score_clr_d;

    // The FSM looks at the incoming debounced level so a release on a tick edge beats the count.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        score_clr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                frame_cnt_d = '0;
                if (hold_next) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!hold_next) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                end else if (frame_tick) begin
                    if (frame_cnt_q != FC_W'(HOLD_FRAMES)) begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                    if (frame_cnt_d == FC_W'(HOLD_FRAMES)) begin
                        score_clr_d = 1'b1;
                        state_d     = ST_FIRED;
                    end
                end
            end
            ST_FIRED: begin
                if (!hold_next) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                frame_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            score_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            score_clr_q <= score_clr_d;
        end
    end

    assign left_up    = left_up_q;
    assign left_down  = left_down_q;
    assign right_up   = right_up_q;
    assign right_down = right_down_q;
    assign score_clr  = score_clr_q;

endmodule

// File: tb/tb_pong_input_cond.sv
// Scoreboard bench for pong_input_cond (DB_CNT_W=4, HOLD_FRAMES=3); adapts to PONG_INPUT_DEBOUNCE_EN.
module tb_pong_input_cond;

`ifdef PONG_INPUT_DEBOUNCE_EN
    localparam int DB_LAT = 18;
    localparam bit DB_ON  = 1'b1;
`else
    localparam int DB_LAT = 2;
    localparam bit DB_ON  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic       frame_tick;
    logic [4:0] btn_stable;
    logic       left_up, left_down, right_up, right_down, score_clr;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [15:0] expQ[$];
    string       nameQ[$];
    logic [15:0] obs, expVal;
    string       nm;

    always #5 clk = ~clk;

    pong_input_cond #(.DB_CNT_W(4), .HOLD_FRAMES(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .frame_tick(frame_tick),
        .btn_stable(btn_stable), .left_up(left_up), .left_down(left_down),
        .right_up(right_up), .right_down(right_down), .score_clr(score_clr)
    );

    function automatic logic [15:0] allOut();
        return {6'd0, score_clr, right_down, right_up, left_down, left_up, btn_stable};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseTick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic settle();
        btn_raw = '0;
        step(DB_LAT + 2);
        pulseTick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_raw = 5'h1F; frame_tick = 1'b1;
        expQ.push_back(16'h0); nameQ.push_back("reset_outputs");
        step(3);
        obs = allOut(); expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        frame_tick = 1'b0; btn_raw = '0; rst_n = 1'b1;
        expQ.push_back(16'h0); nameQ.push_back("idle_after_reset");
        step(DB_LAT + 4);
        obs = allOut(); expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
    endtask

    task automatic test_debounce();
        btn_raw[0] = 1'b1;
        expQ.push_back(16'd0); nameQ.push_back("db_rise_early");
        step(DB_LAT - 1);
        obs = {15'd0, btn_stable[0]}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd1); nameQ.push_back("db_rise_exact");
        step(1);
        obs = {15'd0, btn_stable[0]}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd0); nameQ.push_back("left_up_before_tick");
        obs = {15'd0, left_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'b01); nameQ.push_back("paddle_left_up");
        pulseTick();
        obs = {14'd0, left_down, left_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        btn_raw[0] = 1'b0;
        expQ.push_back(16'd1); nameQ.push_back("left_up_held_in_frame");
        step(DB_LAT + 2);
        obs = {15'd0, left_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd0); nameQ.push_back("left_up_cleared");
        pulseTick();
        obs = {15'd0, left_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        expQ.push_back(DB_ON ? 16'd0 : 16'd1); nameQ.push_back("glitch10_seen");
        btn_raw[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin step(1); seen |= btn_stable[2]; end
        btn_raw[2] = 1'b0;
        for (int c = 0; c < DB_LAT + 4; c++) begin step(1); seen |= btn_stable[2]; end
        obs = {15'd0, seen}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd0); nameQ.push_back("glitch_right_up");
        pulseTick();
        obs = {15'd0, right_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(DB_ON ? 16'd0 : 16'd1); nameQ.push_back("short_glitch_visible");
        btn_raw[3] = 1'b1;
        step(1);
        btn_raw[3] = 1'b0;
        step(1);
        obs = {15'd0, btn_stable[3]}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd0); nameQ.push_back("short_glitch_gone");
        step(1);
        obs = {15'd0, btn_stable[3]}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
    endtask

    task automatic test_both_pressed();
        btn_raw = 5'b00111;
        step(DB_LAT + 2);
        for (int k = 0; k < 3; k++) begin
            expQ.push_back(16'b0100); nameQ.push_back("both_held_frame");
            step(4);
            pulseTick();
            obs = {12'd0, right_down, right_up, left_down, left_up};
            expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
            if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        end
    endtask

    task automatic test_coincide();
        btn_raw[1] = 1'b0;
        expQ.push_back(16'b000); nameQ.push_back("coincide_pre_change");
        step(DB_LAT - 1);
        pulseTick();
        obs = {13'd0, btn_stable[1], left_down, left_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'b001); nameQ.push_back("coincide_next_frame");
        pulseTick();
        obs = {13'd0, btn_stable[1], left_down, left_up}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
    endtask

    task automatic test_hold();
        int highs, tickAt;
        settle();
        for (int p = 0; p < 2; p++) begin
            expQ.push_back(16'd1); nameQ.push_back("hold_pulse_count");
            expQ.push_back(16'd3); nameQ.push_back("hold_pulse_tick");
            btn_raw[4] = 1'b1;
            step(DB_LAT);
            highs = 0; tickAt = 0;
            for (int k = 1; k <= 5; k++) begin
                for (int c = 0; c < 4; c++) begin
                    frame_tick = (c == 3);
                    step(1);
                    if (score_clr) begin highs++; tickAt = k; end
                end
            end
            frame_tick = 1'b0;
            obs = 16'(highs); expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
            if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
            obs = 16'(tickAt); expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
            if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
            btn_raw[4] = 1'b0;
            step(DB_LAT + 2);
        end
    endtask

    task automatic test_release_wins();
        int highs;
        btn_raw[4] = 1'b1;
        step(DB_LAT + 1);
        pulseTick(); step(2); pulseTick();
        btn_raw[4] = 1'b0;
        expQ.push_back(16'b00); nameQ.push_back("release_wins");
        step(DB_LAT - 1);
        pulseTick();
        obs = {14'd0, btn_stable[4], score_clr}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        step(DB_LAT + 2);
        btn_raw[4] = 1'b1;
        step(DB_LAT + 1);
        highs = 0;
        expQ.push_back(16'd0); nameQ.push_back("counter_cleared");
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                frame_tick = (c == 3);
                step(1);
                if (score_clr) highs++;
            end
        end
        frame_tick = 1'b0;
        obs = 16'(highs); expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd1); nameQ.push_back("third_tick_fires");
        pulseTick();
        obs = {15'd0, score_clr}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        settle();
    endtask

    task automatic test_reset_mid();
        btn_raw[1] = 1'b1;
        step(8);
        rst_n = 1'b0;
        expQ.push_back(16'h0); nameQ.push_back("mid_reset_outputs");
        step(1);
        obs = allOut(); expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        rst_n = 1'b1;
        expQ.push_back(16'd0); nameQ.push_back("post_reset_early");
        step(DB_LAT - 1);
        obs = {15'd0, btn_stable[1]}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
        expQ.push_back(16'd1); nameQ.push_back("post_reset_exact");
        step(1);
        obs = {15'd0, btn_stable[1]}; expVal = expQ.pop_front(); nm = nameQ.pop_front(); checkCount++;
        if (obs !== expVal) $display("FAIL %s: observed %0h required %0h", nm, obs, expVal); else passCount++;
    endtask

    initial begin
        rst_n = 1'b0; btn_raw = '0; frame_tick = 1'b0;
        test_reset();
        test_debounce();
        test_glitch();
        test_both_pressed();
        test_coincide();
        test_hold();
        test_release_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
